// File: rtl/operand_fetch_pkg.sv
// Shared widths and constants for the operand-fetch stage of the llama core.
package operand_fetch_pkg;

   localparam int unsigned REG_W      = 5;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned CTRL_W_DEF = 16;
   localparam int unsigned IMM_W_DEF  = 16;

   localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

endpackage

// File: rtl/operand_bypass.sv
// One operand lane: captures a writeback that collides with this cycle's
// register-file read, then resolves the operand (r0 forced to zero).
module operand_bypass
   import operand_fetch_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wb_en,
   input  logic [REG_W-1:0] wb_addr,
   input  logic [XLEN-1:0]  wb_data,
   input  logic [REG_W-1:0] rd_addr,
   input  logic [REG_W-1:0] src,
   input  logic [XLEN-1:0]  rf_data,
   output logic [XLEN-1:0]  op
);

   logic            r_hit;
   logic [XLEN-1:0] r_data;

   // Register file returns the pre-write value on a same-edge write/read
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_hit  <= 1'b0;
         r_data <= '0;
      end else begin
         r_hit  <= wb_en && (wb_addr == rd_addr) && (rd_addr != REG_ZERO);
         r_data <= wb_data;
      end
   end

   assign op = (src == REG_ZERO) ? '0 : (r_hit ? r_data : rf_data);

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute stage: single holding slot, register-file read address
// steering, writeback bypass and immediate selection for operand B.
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int unsigned CTRL_W = CTRL_W_DEF,
   parameter int unsigned IMM_W  = IMM_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_W-1:0]  in_rs,
   input  logic [REG_W-1:0]  in_rt,
   input  logic [REG_W-1:0]  in_rd,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic              in_use_imm,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic [REG_W-1:0]  rf_addr_a,
   output logic [REG_W-1:0]  rf_addr_b,
   input  logic [XLEN-1:0]   rf_data_a,
   input  logic [XLEN-1:0]   rf_data_b,
   input  logic              wb_en,
   input  logic [REG_W-1:0]  wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_op_a,
   output logic [XLEN-1:0]   out_op_b,
   output logic [REG_W-1:0]  out_rd,
   output logic [CTRL_W-1:0] out_ctrl
);

   logic              r_valid;
   logic [REG_W-1:0]  r_rs;
   logic [REG_W-1:0]  r_rt;
   logic [REG_W-1:0]  r_rd;
   logic [IMM_W-1:0]  r_imm;
   logic              r_use_imm;
   logic [CTRL_W-1:0] r_ctrl;

   logic              w_stall;
   logic              w_accept;
   logic [XLEN-1:0]   w_op_b_reg;

   assign w_stall  = r_valid && !out_ready;
   assign in_ready = !r_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   // While stalled keep re-reading the held sources so writebacks are seen
   assign rf_addr_a = w_stall ? r_rs : in_rs;
   assign rf_addr_b = w_stall ? r_rt : in_rt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_valid   <= 1'b0;
         r_rs      <= '0;
         r_rt      <= '0;
         r_rd      <= '0;
         r_imm     <= '0;
         r_use_imm <= 1'b0;
         r_ctrl    <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid   <= 1'b1;
         r_rs      <= in_rs;
         r_rt      <= in_rt;
         r_rd      <= in_rd;
         r_imm     <= in_imm;
         r_use_imm <= in_use_imm;
         r_ctrl    <= in_ctrl;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   operand_bypass u_byp_a (
      .clk     (clk),
      .rst     (rst),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .rd_addr (rf_addr_a),
      .src     (r_rs),
      .rf_data (rf_data_a),
      .op      (out_op_a)
   );

   operand_bypass u_byp_b (
      .clk     (clk),
      .rst     (rst),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .rd_addr (rf_addr_b),
      .src     (r_rt),
      .rf_data (rf_data_b),
      .op      (w_op_b_reg)
   );

   assign out_op_b  = r_use_imm ? XLEN'($signed(r_imm)) : w_op_b_reg;
   assign out_valid = r_valid;
   assign out_rd    = r_rd;
   assign out_ctrl  = r_ctrl;

endmodule
